// File: rtl/mod_scheduler_if.sv
// rtl/mod_scheduler_if.sv - scheduler control, FIFO read and modulator signal bundle
interface mod_scheduler_if;
  logic       start;
  logic [1:0] mode;
  logic [7:0] burst_len;
  logic       fifo_empty;
  logic       fifo_ack;
  logic       fifo_dout;
  logic       fifo_rd_en;
  logic [1:0] mod_sel;
  logic [1:0] mod_sym;
  logic       mod_en;
  logic       sym_strobe;
  logic       busy;
  logic       done;
  logic       underrun;
  logic       timeout_err;

  modport master (
    output start, mode, burst_len, fifo_empty, fifo_ack, fifo_dout,
    input  fifo_rd_en, mod_sel, mod_sym, mod_en, sym_strobe, busy, done,
           underrun, timeout_err
  );

  modport slave (
    input  start, mode, burst_len, fifo_empty, fifo_ack, fifo_dout,
    output fifo_rd_en, mod_sel, mod_sym, mod_en, sym_strobe, busy, done,
           underrun, timeout_err
  );
endinterface

// File: rtl/mod_scheduler.sv
// rtl/mod_scheduler.sv - burst scheduler packing FIFO bits into timed modulator symbols
module mod_scheduler #(
  parameter int SYM_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input logic           CLK,
  input logic           RESET,
  mod_scheduler_if.slave sched
);

  typedef enum logic {S_IDLE, S_RUN} top_state_t;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fetch_state_t;

  localparam logic [7:0] SYM_LAST = 8'(SYM_CYCLES - 1);
  localparam logic [3:0] ACK_LAST = 4'(ACK_TIMEOUT - 1);

  top_state_t   state, state_nxt;
  fetch_state_t fstate, fstate_nxt;

  logic [1:0] mode_q;
  logic [7:0] len_q;
  logic [1:0] gather;
  logic [1:0] gather_bits;
  logic       gather_full;
  logic [1:0] shadow;
  logic       shadow_full;
  logic [7:0] fetched;
  logic [7:0] emitted;
  logic [7:0] sym_cnt;
  logic [3:0] wait_cnt;
  logic [1:0] mod_sym_q;
  logic       mod_en_q;
  logic       sym_strobe_q;
  logic       done_q;
  logic       underrun_q;
  logic       timeout_q;
  logic       busy_c;
  logic       rd_en_c;

  logic       start_ok;
  logic       run;
  logic [1:0] bits_needed;
  logic [1:0] bits_after;
  logic       ack_take;
  logic       ack_completes;
  logic       timeout;
  logic       sym_last;
  logic       emit_load;
  logic       transfer;
  logic       burst_end;
  logic       starve;

  assign start_ok      = (state == S_IDLE) && sched.start;
  assign run           = (state == S_RUN);
  assign bits_needed   = (mode_q == 2'b11) ? 2'd2 : 2'd1;
  assign bits_after    = gather_bits + 2'd1;
  assign ack_take      = run && (fstate == F_WAIT) && sched.fifo_ack;
  assign ack_completes = ack_take && (bits_after == bits_needed);
  assign timeout       = run && (fstate == F_WAIT) && !sched.fifo_ack && (wait_cnt == ACK_LAST);
  assign sym_last      = mod_en_q && (sym_cnt == SYM_LAST);
  assign emit_load     = run && shadow_full && (!mod_en_q || sym_last);
  // The shadow counts as free in the cycle it is being emitted, so gather and
  // shadow can hand over without a bubble.
  assign transfer      = run && gather_full && (!shadow_full || emit_load);
  assign burst_end     = run && sym_last && !emit_load && (emitted == len_q);
  assign starve        = run && sym_last && !emit_load && (emitted != len_q);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      fstate <= F_IDLE;
    end else begin
      state  <= state_nxt;
      fstate <= fstate_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_ok && (sched.burst_len != 8'd0)) state_nxt = S_RUN;
      S_RUN:  if (burst_end || timeout) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    fstate_nxt = fstate;
    case (fstate)
      F_IDLE: begin
        if (start_ok || (transfer && (fetched < len_q))) fstate_nxt = F_REQ;
      end
      F_REQ: begin
        if (!sched.fifo_empty) fstate_nxt = F_WAIT;
      end
      F_WAIT: begin
        if (ack_take) fstate_nxt = ack_completes ? F_IDLE : F_REQ;
        else if (timeout) fstate_nxt = F_IDLE;
      end
      default: fstate_nxt = F_IDLE;
    endcase
    if (state_nxt == S_IDLE) fstate_nxt = F_IDLE;
  end

  always_comb begin
    busy_c  = run;
    rd_en_c = run && (fstate == F_REQ) && !sched.fifo_empty;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mode_q       <= 2'b00;
      len_q        <= 8'd0;
      gather       <= 2'b00;
      gather_bits  <= 2'd0;
      gather_full  <= 1'b0;
      shadow       <= 2'b00;
      shadow_full  <= 1'b0;
      fetched      <= 8'd0;
      emitted      <= 8'd0;
      sym_cnt      <= 8'd0;
      wait_cnt     <= 4'd0;
      mod_sym_q    <= 2'b00;
      mod_en_q     <= 1'b0;
      sym_strobe_q <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      sym_strobe_q <= 1'b0;
      done_q       <= 1'b0;
      wait_cnt     <= (fstate == F_WAIT) ? wait_cnt + 4'd1 : 4'd0;

      if (start_ok) begin
        mode_q      <= sched.mode;
        len_q       <= sched.burst_len;
        underrun_q  <= 1'b0;
        timeout_q   <= 1'b0;
        fetched     <= 8'd0;
        emitted     <= 8'd0;
        gather      <= 2'b00;
        gather_bits <= 2'd0;
        gather_full <= 1'b0;
        shadow_full <= 1'b0;
        sym_cnt     <= 8'd0;
        mod_en_q    <= 1'b0;
        if (sched.burst_len == 8'd0) done_q <= 1'b1;
      end else if (timeout) begin
        timeout_q   <= 1'b1;
        mod_en_q    <= 1'b0;
        gather_bits <= 2'd0;
        gather_full <= 1'b0;
        shadow_full <= 1'b0;
      end else if (run) begin
        // First bit read lands in the MSB once the second bit shifts in.
        if (ack_take) begin
          gather      <= {gather[0], sched.fifo_dout};
          gather_bits <= bits_after;
          if (ack_completes) begin
            gather_full <= 1'b1;
            fetched     <= fetched + 8'd1;
          end
        end

        if (transfer) begin
          shadow      <= gather;
          shadow_full <= 1'b1;
          gather      <= 2'b00;
          gather_bits <= 2'd0;
          gather_full <= 1'b0;
        end else if (emit_load) begin
          shadow_full <= 1'b0;
        end

        if (emit_load) begin
          mod_sym_q    <= shadow;
          mod_en_q     <= 1'b1;
          sym_cnt      <= 8'd0;
          sym_strobe_q <= 1'b1;
          emitted      <= emitted + 8'd1;
        end else if (burst_end) begin
          mod_en_q <= 1'b0;
          done_q   <= 1'b1;
        end else if (starve) begin
          mod_en_q   <= 1'b0;
          underrun_q <= 1'b1;
        end else if (mod_en_q) begin
          sym_cnt <= sym_cnt + 8'd1;
        end
      end
    end
  end

  assign sched.fifo_rd_en  = rd_en_c;
  assign sched.busy        = busy_c;
  assign sched.mod_sel     = mode_q;
  assign sched.mod_sym     = mod_sym_q;
  assign sched.mod_en      = mod_en_q;
  assign sched.sym_strobe  = sym_strobe_q;
  assign sched.done        = done_q;
  assign sched.underrun    = underrun_q;
  assign sched.timeout_err = timeout_q;

endmodule

// File: tb/tb_mod_scheduler.sv
// tb/tb_mod_scheduler.sv - scoreboard bench for mod_scheduler with a behavioural bit FIFO
module tb_mod_scheduler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_scheduler_if bus();
  mod_scheduler #(.SYM_CYCLES(16), .ACK_TIMEOUT(8)) dut (.CLK(clk), .RESET(rst), .sched(bus));

  int vectors = 0;
  int miscompares = 0;

  bit         fifo_q[$];
  logic [1:0] exp_sym[$];
  int ack_delay = 1;
  bit ack_on = 1'b1;
  int pend = 0;
  int req_cnt = 0;

  int mon_strobes = 0, mon_en_cycles = 0, mon_en_runs = 0, mon_dones = 0;
  int gap_min = 1000, gap_max = 0, last_strobe = -1, cyc = 0, b2b = 0;
  bit prev_en = 1'b0, prev_rd = 1'b0;

  // FIFO: a request seen during a cycle is acknowledged ack_delay cycles later.
  initial begin
    bus.fifo_ack = 1'b0;
    bus.fifo_dout = 1'b0;
    bus.fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      bus.fifo_ack = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && fifo_q.size() > 0) begin
          bus.fifo_dout = fifo_q.pop_front();
          bus.fifo_ack = 1'b1;
        end
      end
      bus.fifo_empty = (fifo_q.size() == 0);
      #1;
      if (bus.fifo_rd_en === 1'b1) begin
        req_cnt++;
        if (ack_on) pend = ack_delay;
      end
    end
  end

  initial begin : monitor
    logic [1:0] e;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (bus.sym_strobe === 1'b1) begin
        mon_strobes++;
        if (last_strobe >= 0) begin
          if (cyc - last_strobe < gap_min) gap_min = cyc - last_strobe;
          if (cyc - last_strobe > gap_max) gap_max = cyc - last_strobe;
        end
        last_strobe = cyc;
        vectors++;
        if (exp_sym.size() == 0) begin
          miscompares++;
          $display("FAIL sym_unexpected: got mod_sym=%0d, expected no strobe", bus.mod_sym);
        end else begin
          e = exp_sym.pop_front();
          if (bus.mod_sym !== e) begin
            miscompares++;
            $display("FAIL sym_value: got %0d, expected %0d", bus.mod_sym, e);
          end
        end
      end
      if (bus.mod_en === 1'b1) mon_en_cycles++;
      if (bus.mod_en === 1'b1 && !prev_en) mon_en_runs++;
      prev_en = (bus.mod_en === 1'b1);
      if (bus.done === 1'b1) mon_dones++;
      if (bus.fifo_rd_en === 1'b1 && prev_rd) b2b++;
      prev_rd = (bus.fifo_rd_en === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] get_outs();
    return {bus.fifo_rd_en, bus.mod_sel, bus.mod_sym, bus.mod_en, bus.sym_strobe,
            bus.busy, bus.done, bus.underrun, bus.timeout_err};
  endfunction

  task automatic clear_mon();
    mon_strobes = 0; mon_en_cycles = 0; mon_en_runs = 0; mon_dones = 0;
    gap_min = 1000; gap_max = 0; last_strobe = -1; b2b = 0; req_cnt = 0;
  endtask

  task automatic load_fifo(input logic [15:0] bits, input int n, input bit qpsk);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(bits[i]);
      if (!qpsk) exp_sym.push_back({1'b0, bits[i]});
      else if (i % 2 == 1) exp_sym.push_back({bits[i-1], bits[i]});
    end
  endtask

  task automatic start_burst(input logic [1:0] m, input logic [7:0] len);
    @(negedge clk);
    bus.mode = m;
    bus.burst_len = len;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      #3;
      if (bus.done === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.mode = 2'b11; bus.burst_len = 8'd3;
    @(posedge clk);
    @(negedge clk);
    #3;
    vectors++;
    if (get_outs() !== 12'h000) begin
      miscompares++; $display("FAIL reset_outputs: got %h, expected 000", get_outs());
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #3;
    vectors++;
    if (get_outs() !== 12'h000) begin
      miscompares++; $display("FAIL reset_release: got %h, expected 000", get_outs());
    end
  endtask

  task automatic test_bpsk();
    bit got;
    clear_mon();
    load_fifo(16'h00AA, 8, 1'b0);
    start_burst(2'b10, 8'd8);
    wait_done(400, got);
    repeat (4) @(negedge clk);
    #3;
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL bpsk_done: got %0b, expected 1", got); end
    vectors++; if (mon_strobes !== 8) begin miscompares++; $display("FAIL bpsk_strobes: got %0d, expected 8", mon_strobes); end
    vectors++; if (gap_min !== 16 || gap_max !== 16) begin miscompares++; $display("FAIL bpsk_spacing: got %0d..%0d, expected 16", gap_min, gap_max); end
    vectors++; if (mon_en_cycles !== 128 || mon_en_runs !== 1) begin miscompares++; $display("FAIL bpsk_mod_en: got %0d cycles in %0d runs, expected 128 in 1", mon_en_cycles, mon_en_runs); end
    vectors++; if (mon_dones !== 1) begin miscompares++; $display("FAIL bpsk_done_count: got %0d, expected 1", mon_dones); end
    vectors++; if (bus.underrun !== 1'b0) begin miscompares++; $display("FAIL bpsk_underrun: got %0b, expected 0", bus.underrun); end
    vectors++; if (req_cnt !== 8 || b2b !== 0) begin miscompares++; $display("FAIL bpsk_reads: got %0d reads, %0d back-to-back, expected 8 and 0", req_cnt, b2b); end
    vectors++; if (exp_sym.size() !== 0) begin miscompares++; $display("FAIL bpsk_scoreboard: got %0d left, expected 0", exp_sym.size()); end
    vectors++; if (bus.mod_sym !== 2'd1 || bus.mod_sel !== 2'b10 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL bpsk_hold: got sym=%0d sel=%0d busy=%0b, expected 1 2 0", bus.mod_sym, bus.mod_sel, bus.busy); end
  endtask

  task automatic test_qpsk();
    bit got;
    clear_mon();
    load_fifo(16'h008D, 8, 1'b1);
    start_burst(2'b11, 8'd4);
    wait_done(300, got);
    repeat (4) @(negedge clk);
    #3;
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL qpsk_done: got %0b, expected 1", got); end
    vectors++; if (req_cnt !== 8) begin miscompares++; $display("FAIL qpsk_reads: got %0d, expected 8", req_cnt); end
    vectors++; if (mon_strobes !== 4 || mon_en_cycles !== 64 || mon_en_runs !== 1) begin miscompares++; $display("FAIL qpsk_timing: got %0d strobes %0d cycles %0d runs, expected 4 64 1", mon_strobes, mon_en_cycles, mon_en_runs); end
    vectors++; if (exp_sym.size() !== 0) begin miscompares++; $display("FAIL qpsk_scoreboard: got %0d left, expected 0", exp_sym.size()); end
  endtask

  task automatic test_underrun();
    bit got, seen_ur, en_at_ur;
    clear_mon();
    seen_ur = 1'b0;
    en_at_ur = 1'b1;
    load_fifo(16'h0001, 2, 1'b0);
    start_burst(2'b10, 8'd4);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #3;
      if (bus.underrun === 1'b1 && !seen_ur) begin
        seen_ur = 1'b1;
        en_at_ur = bus.mod_en;
      end
    end
    load_fifo(16'h0003, 2, 1'b0);
    wait_done(200, got);
    repeat (4) @(negedge clk);
    #3;
    vectors++; if (seen_ur !== 1'b1 || en_at_ur !== 1'b0) begin miscompares++; $display("FAIL underrun_flag: got seen=%0b mod_en=%0b, expected 1 0", seen_ur, en_at_ur); end
    vectors++; if (got !== 1'b1 || mon_dones !== 1) begin miscompares++; $display("FAIL underrun_done: got %0b/%0d, expected 1/1", got, mon_dones); end
    vectors++; if (mon_strobes !== 4 || mon_en_runs !== 2 || mon_en_cycles !== 64) begin miscompares++; $display("FAIL underrun_symbols: got %0d strobes %0d runs %0d cycles, expected 4 2 64", mon_strobes, mon_en_runs, mon_en_cycles); end
    vectors++; if (bus.underrun !== 1'b1 || exp_sym.size() !== 0) begin miscompares++; $display("FAIL underrun_sticky: got %0b with %0d left, expected 1 and 0", bus.underrun, exp_sym.size()); end
  endtask

  task automatic test_timeout();
    int i;
    clear_mon();
    ack_on = 1'b0;
    fifo_q.push_back(1'b1);
    start_burst(2'b10, 8'd2);
    #3;
    vectors++; if (bus.underrun !== 1'b0) begin miscompares++; $display("FAIL timeout_clear_underrun: got %0b, expected 0", bus.underrun); end
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      #3;
      if (bus.busy !== 1'b1) break;
    end
    vectors++; if (i >= 40) begin miscompares++; $display("FAIL timeout_abort: got busy=%0b after 40 cycles, expected 0", bus.busy); end
    vectors++; if (bus.timeout_err !== 1'b1 || bus.mod_en !== 1'b0) begin miscompares++; $display("FAIL timeout_flag: got err=%0b mod_en=%0b, expected 1 0", bus.timeout_err, bus.mod_en); end
    repeat (10) @(negedge clk);
    #3;
    vectors++; if (req_cnt !== 1 || mon_dones !== 0 || bus.timeout_err !== 1'b1) begin miscompares++; $display("FAIL timeout_after: got %0d reads %0d dones err=%0b, expected 1 0 1", req_cnt, mon_dones, bus.timeout_err); end
    ack_on = 1'b1;
    fifo_q.delete();
  endtask

  task automatic test_zero_len();
    clear_mon();
    start_burst(2'b00, 8'd0);
    #3;
    vectors++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL zero_done: got done=%0b busy=%0b, expected 1 0", bus.done, bus.busy); end
    vectors++; if (bus.timeout_err !== 1'b0) begin miscompares++; $display("FAIL zero_clear_timeout: got %0b, expected 0", bus.timeout_err); end
    @(negedge clk);
    #3;
    vectors++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL zero_pulse: got done=%0b busy=%0b, expected 0 0", bus.done, bus.busy); end
    repeat (5) @(negedge clk);
    #3;
    vectors++; if (req_cnt !== 0 || mon_dones !== 1) begin miscompares++; $display("FAIL zero_reads: got %0d reads %0d dones, expected 0 1", req_cnt, mon_dones); end
  endtask

  task automatic test_start_while_busy();
    bit got;
    clear_mon();
    load_fifo(16'h0001, 2, 1'b0);
    start_burst(2'b10, 8'd2);
    repeat (10) @(negedge clk);
    bus.mode = 2'b11;
    bus.burst_len = 8'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #3;
    vectors++; if (bus.mod_sel !== 2'b10 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL busy_start_sel: got sel=%0d busy=%0b, expected 2 1", bus.mod_sel, bus.busy); end
    wait_done(200, got);
    repeat (4) @(negedge clk);
    #3;
    vectors++; if (got !== 1'b1 || mon_strobes !== 2 || mon_dones !== 1) begin miscompares++; $display("FAIL busy_start_burst: got done=%0b %0d strobes %0d dones, expected 1 2 1", got, mon_strobes, mon_dones); end
    vectors++; if (req_cnt !== 2 || exp_sym.size() !== 0 || bus.mod_sel !== 2'b10) begin miscompares++; $display("FAIL busy_start_reads: got %0d reads %0d left sel=%0d, expected 2 0 2", req_cnt, exp_sym.size(), bus.mod_sel); end
  endtask

  task automatic test_reset_mid();
    bit got;
    int i, r0;
    clear_mon();
    load_fifo(16'h00F3, 8, 1'b0);
    start_burst(2'b10, 8'd8);
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      #3;
      if (mon_strobes >= 3) break;
    end
    vectors++; if (i >= 200) begin miscompares++; $display("FAIL rstmid_reach: got %0d strobes, expected 3", mon_strobes); end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #3;
    vectors++; if (get_outs() !== 12'h000) begin miscompares++; $display("FAIL rstmid_outputs: got %h, expected 000", get_outs()); end
    r0 = req_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #3;
    vectors++; if (req_cnt !== r0 || mon_dones !== 0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_quiet: got %0d new reads %0d dones busy=%0b, expected 0 0 0", req_cnt - r0, mon_dones, bus.busy); end
    fifo_q.delete();
    exp_sym.delete();
    pend = 0;
    clear_mon();
    load_fifo(16'h0006, 4, 1'b1);
    start_burst(2'b11, 8'd2);
    wait_done(200, got);
    repeat (4) @(negedge clk);
    #3;
    vectors++; if (got !== 1'b1 || mon_strobes !== 2 || mon_dones !== 1) begin miscompares++; $display("FAIL rstmid_rerun: got done=%0b %0d strobes %0d dones, expected 1 2 1", got, mon_strobes, mon_dones); end
    vectors++; if (req_cnt !== 4 || exp_sym.size() !== 0 || bus.underrun !== 1'b0 || bus.timeout_err !== 1'b0) begin miscompares++; $display("FAIL rstmid_clean: got %0d reads %0d left ur=%0b to=%0b, expected 4 0 0 0", req_cnt, exp_sym.size(), bus.underrun, bus.timeout_err); end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.mode = 2'b00;
    bus.burst_len = 8'd0;
    test_reset();
    test_bpsk();
    test_qpsk();
    test_underrun();
    test_timeout();
    test_zero_len();
    test_start_while_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
